// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: command-byte layout and the
// SPI command decoder state encoding.
package pwm_pkg;

  localparam int REG_ADDR_W   = 6;
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_DATA   = 3'd1,
    WR_STROBE = 3'd2,
    WR_NEXT   = 3'd3,
    RD_STROBE = 3'd4,
    RD_LOAD   = 3'd5,
    RD_NEXT   = 3'd6
  } dcd_state_t;

endpackage

// File: rtl/instr_dcd.sv
// SPI command decoder: turns the received byte stream into register read/write
// strobes with auto-incrementing burst addressing, and returns read bytes to the bridge.
module instr_dcd
  import pwm_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  dcd_state_t        state_r;
  logic              armed_r;
  logic              read_r;
  logic              write_r;
  logic              tx_load_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_write_r;
  logic [DATA_W-1:0] tx_data_r;

  // armed_r allows one command per frame; it is only re-armed while chip-select
  // is low, so a reset in mid-frame cannot reinterpret a data byte as a command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      armed_r      <= 1'b0;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      tx_load_r    <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      data_write_r <= {DATA_W{1'b0}};
      tx_data_r    <= {DATA_W{1'b0}};
    end else begin
      read_r    <= 1'b0;
      write_r   <= 1'b0;
      tx_load_r <= 1'b0;
      if (state_r == RD_STROBE) begin
        tx_data_r <= data_read;
      end else begin
        tx_data_r <= tx_data_r;
      end
      if (!frame_active) begin
        state_r <= IDLE;
        armed_r <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            if (rx_valid && armed_r) begin
              armed_r <= 1'b0;
              addr_r  <= rx_data[CMD_ADDR_LSB +: ADDR_W];
              if (rx_data[CMD_RW_BIT]) begin
                state_r <= WR_DATA;
              end else begin
                read_r  <= 1'b1;
                state_r <= RD_STROBE;
              end
            end else begin
              state_r <= IDLE;
            end
          end
          WR_DATA: begin
            if (rx_valid) begin
              data_write_r <= rx_data;
              write_r      <= 1'b1;
              state_r      <= WR_STROBE;
            end else begin
              state_r <= WR_DATA;
            end
          end
          WR_STROBE: state_r <= WR_NEXT;
          WR_NEXT: begin
            if (rx_valid) begin
              addr_r       <= addr_r + ADDR_ONE;
              data_write_r <= rx_data;
              write_r      <= 1'b1;
              state_r      <= WR_STROBE;
            end else begin
              state_r <= WR_NEXT;
            end
          end
          RD_STROBE: begin
            tx_load_r <= 1'b1;
            state_r   <= RD_LOAD;
          end
          RD_LOAD: state_r <= RD_NEXT;
          RD_NEXT: begin
            if (rx_valid) begin
              addr_r  <= addr_r + ADDR_ONE;
              read_r  <= 1'b1;
              state_r <= RD_STROBE;
            end else begin
              state_r <= RD_NEXT;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign read       = read_r;
  assign write      = write_r;
  assign tx_load    = tx_load_r;
  assign addr       = addr_r;
  assign data_write = data_write_r;
  assign tx_data    = tx_data_r;

endmodule

// File: doc/instr_dcd.md
# instr_dcd

Command decoder between the SPI byte bridge and the PWM register file. It turns the incoming SPI byte stream into single-cycle `read`/`write` strobes with `addr`/`data_write`. For reads, it returns the register byte to the bridge for shifting out. Frames may carry bursts with auto-incrementing address; a frame ends when chip-select deasserts.

## Interface
Parameters:
- ADDR_W, 6, register address width
- DATA_W, 8, byte width

Ports:
- clk  in  1  peripheral clock
- rst  in  1  reset, synchronous, active-high; one clock
- frame_active  in  1  SPI chip-select asserted (frame in progress)
- rx_valid  in  1  one-cycle pulse, `rx_data` holds a complete received byte
- rx_data  in  DATA_W  received byte
- tx_data  out  DATA_W  byte the bridge shifts out on the next transfer
- tx_load  out  1  one-cycle pulse, `tx_data` newly valid
- read  out  1  register read strobe
- write  out  1  register write strobe
- addr  out  ADDR_W  register address
- data_write  out  DATA_W  write data
- data_read  in  DATA_W  combinational read data from the register file

## Operation
- Command byte: first byte after `frame_active` rises.
  - bit7 = 1 write, 0 read.
  - bit6 reserved, ignored.
  - bits5:0 = start address.
- States:
  - IDLE: waits for a command byte; on it, latch `addr`.
    - Command bit7 = 1 → WR_DATA.
    - Command bit7 = 0 → RD_STROBE.
  - WR_DATA: on `rx_valid`, latch `data_write` → WR_STROBE.
  - WR_STROBE: `write` = 1 for exactly this cycle → WR_NEXT.
  - WR_NEXT: on `rx_valid`, `addr` = `addr` + 1, latch the byte → WR_STROBE (burst write).
  - RD_STROBE: `read` = 1 for exactly this cycle; capture `data_read` into `tx_data` at the clock edge ending the cycle → RD_LOAD.
  - RD_LOAD: `tx_load` = 1 for one cycle → RD_NEXT.
  - RD_NEXT: on `rx_valid` (dummy byte, contents ignored), `addr` = `addr` + 1 → RD_STROBE (burst read).
- Address increment is modulo 2^ADDR_W: 63 → 0. No range check; the register file handles invalid addresses.
- `frame_active` low in any state → IDLE on the next edge.
  - No strobe is issued.
  - A strobe already in progress completes.
  - A partially received write (WR_DATA) is discarded.
- `rx_valid` while `frame_active` is low: ignored.
- `rx_valid` during WR_STROBE, RD_STROBE or RD_LOAD: byte dropped. The bridge guarantees ≥ 8 cycles between bytes.
- `read` and `write` are never high in the same cycle.

## Timing
- All outputs registered.
- Reset values: `read` = 0, `write` = 0, `tx_load` = 0, `addr` = 0, `data_write` = 0, `tx_data` = 0, state IDLE.
- Reset mid-frame: strobes drop the same cycle `rst` is sampled; nothing resumes after reset until a new frame starts.
- Read latency: command `rx_valid` at edge N → `read` high in cycle N+1 → `tx_load` high in cycle N+2, with `tx_data` = register value at cycle N+1.
- Write latency: data `rx_valid` at edge M → `write` high in cycle M+1, with `addr` and `data_write` stable throughout that cycle.
- `addr` and `data_write` hold their value between strobes.

## Structure
- Shared package `pwm_pkg`:
  - state enum `dcd_state_t` (IDLE, WR_DATA, WR_STROBE, WR_NEXT, RD_STROBE, RD_LOAD, RD_NEXT)
  - `CMD_RW_BIT` = 7
  - `CMD_ADDR_LSB` = 0
  - `REG_ADDR_W` = 6
- Single flat module, no sub-module: one state register, address counter, data and tx latches.

## Test plan
- Single write: frame, bytes 0x80, 0x5A → one `write` pulse with `addr` = 0x00, `data_write` = 0x5A; `read` never asserted.
- Single read: regs model returns 0x3C at `addr` 0x0D; bytes 0x0D, dummy → `read` pulse with `addr` = 0x0D; next cycle `tx_load` = 1 with `tx_data` = 0x3C.
- Burst write with wrap: bytes 0xBF, 0x11, 0x22, 0x33 → writes (0x3F, 0x11), (0x00, 0x22), (0x01, 0x33).
- Abort: bytes 0x83, then `frame_active` drops before the data byte → no `write`. Next frame 0x03 → read at `addr` 0x03.
- Reset mid-burst read: `rst` asserted during RD_LOAD → `tx_load`, `read`, `addr` all 0 next cycle; state IDLE.
- Back-to-back violation: `rx_valid` during WR_STROBE → byte dropped, exactly one `write` issued.
